// File: rtl/axis_pkt_framer.sv
// axis_pkt_framer: frames a merged word stream into AXI4-Stream packets, inserting tlast by word count.
// Define AXIS_PKT_FRAMER_TIMEOUT_EN to add one-word lookahead and the input-idle timeout close.

module axis_pkt_framer #(
   parameter int DATA_WD = 64,
   parameter int LEN_WD  = 16,
   parameter int TO_WD   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               s_axis_tvalid,
   input  logic [DATA_WD-1:0] s_axis_tdata,
   output logic               s_axis_tready,
   input  logic [LEN_WD-1:0]  pkt_len,
   input  logic [TO_WD-1:0]   timeout,
   output logic               m_axis_tvalid,
   output logic [DATA_WD-1:0] m_axis_tdata,
   output logic               m_axis_tlast,
   input  logic               m_axis_tready,
   output logic               pkt_done,
   output logic               to_flush
);

   localparam logic [LEN_WD-1:0] LEN_ZERO = {LEN_WD{1'b0}};
   localparam logic [LEN_WD-1:0] LEN_ONE  = {{(LEN_WD-1){1'b0}}, 1'b1};

   logic               h_valid_r;
   logic [DATA_WD-1:0] h_data_r;
   logic               o_valid_r;
   logic [DATA_WD-1:0] o_data_r;
   logic               o_last_r;
   logic [LEN_WD-1:0]  cnt_r;
   logic [LEN_WD-1:0]  len_q_r;
   logic               pkt_done_r;

   logic               push_ok_s;
   logic               accept_s;
   logic               h_last_s;
   logic               push_s;
   logic               start_s;

`ifdef AXIS_PKT_FRAMER_TIMEOUT_EN
   logic               h_force_r;
   logic [TO_WD-1:0]   idle_r;
   logic               to_flush_r;
   logic [TO_WD-1:0]   idle_inc_s;
   logic               fire_s;
`else
   logic               unused_timeout_s;
   assign unused_timeout_s = ^timeout;
`endif

   assign s_axis_tready = !h_valid_r | push_ok_s;

   // Push/accept decisions and packet-boundary detection
   always_comb begin
      push_ok_s = !o_valid_r | m_axis_tready;
      accept_s  = s_axis_tvalid & s_axis_tready;
`ifdef AXIS_PKT_FRAMER_TIMEOUT_EN
      h_last_s   = (cnt_r + LEN_ONE == len_q_r) | h_force_r;
      // A non-last word waits in H for its successor so it can still become the tlast beat.
      push_s     = h_valid_r & push_ok_s & (h_last_s | accept_s);
      idle_inc_s = idle_r + {{(TO_WD-1){1'b0}}, 1'b1};
      fire_s     = h_valid_r & !h_last_s & !accept_s &
                   (timeout != {TO_WD{1'b0}}) & (idle_inc_s == timeout);
`else
      h_last_s = (cnt_r + LEN_ONE == len_q_r);
      push_s   = h_valid_r & push_ok_s;
`endif
      // The incoming word opens a packet when nothing of the current packet remains ahead of it.
      if (h_valid_r) begin
         start_s = push_s & h_last_s;
      end else begin
         start_s = (cnt_r == LEN_ZERO);
      end
   end

   // Hold register, packet word counter and latched packet length
   always_ff @(posedge clk) begin
      if (rst) begin
         h_valid_r <= 1'b0;
         h_data_r  <= {DATA_WD{1'b0}};
         cnt_r     <= LEN_ZERO;
         len_q_r   <= LEN_ONE;
      end else begin
         if (accept_s) begin
            h_valid_r <= 1'b1;
            h_data_r  <= s_axis_tdata;
         end else if (push_s) begin
            h_valid_r <= 1'b0;
         end
         if (push_s) begin
            cnt_r <= h_last_s ? LEN_ZERO : cnt_r + LEN_ONE;
         end
         if (accept_s & start_s) begin
            len_q_r <= (pkt_len == LEN_ZERO) ? LEN_ONE : pkt_len;
         end
      end
   end

   // Output register and tlast-handshake pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         o_valid_r  <= 1'b0;
         o_data_r   <= {DATA_WD{1'b0}};
         o_last_r   <= 1'b0;
         pkt_done_r <= 1'b0;
      end else begin
         pkt_done_r <= o_valid_r & m_axis_tready & o_last_r;
         if (push_s) begin
            o_valid_r <= 1'b1;
            o_data_r  <= h_data_r;
            o_last_r  <= h_last_s;
         end else if (m_axis_tready) begin
            o_valid_r <= 1'b0;
         end
      end
   end

`ifdef AXIS_PKT_FRAMER_TIMEOUT_EN
   // Idle counter and forced close; an accept in the firing cycle cancels the close
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_r     <= {TO_WD{1'b0}};
         h_force_r  <= 1'b0;
         to_flush_r <= 1'b0;
      end else begin
         to_flush_r <= fire_s;
         if (accept_s | push_s) begin
            idle_r    <= {TO_WD{1'b0}};
            h_force_r <= 1'b0;
         end else if (fire_s) begin
            idle_r    <= idle_inc_s;
            h_force_r <= 1'b1;
         end else if (h_valid_r & !h_last_s) begin
            idle_r <= idle_inc_s;
         end
      end
   end

   assign to_flush = to_flush_r;
`else
   assign to_flush = 1'b0;
`endif

   assign m_axis_tvalid = o_valid_r;
   assign m_axis_tdata  = o_data_r;
   assign m_axis_tlast  = o_last_r;
   assign pkt_done      = pkt_done_r;

endmodule

// File: tb/tb_axis_pkt_framer.sv
// tb_axis_pkt_framer: directed self-checking bench for axis_pkt_framer (both AXIS_PKT_FRAMER_TIMEOUT_EN builds).

module tb_axis_pkt_framer;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_axis_tvalid;
   logic [63:0] s_axis_tdata;
   logic        s_axis_tready;
   logic [15:0] pkt_len;
   logic [15:0] timeout;
   logic        m_axis_tvalid;
   logic [63:0] m_axis_tdata;
   logic        m_axis_tlast;
   logic        m_axis_tready;
   logic        pkt_done;
   logic        to_flush;

   int checks = 0;
   int errors = 0;

   axis_pkt_framer #(.DATA_WD(64), .LEN_WD(16), .TO_WD(16)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tready(s_axis_tready),
      .pkt_len(pkt_len), .timeout(timeout),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
      .m_axis_tready(m_axis_tready), .pkt_done(pkt_done), .to_flush(to_flush)
   );

   always #5 clk = ~clk;

   // Output-side record: handshaken beats with the edge after which each became visible
   logic [63:0] out_data [0:511];
   logic        out_last [0:511];
   int          out_cyc  [0:511];
   int          out_n = 0;
   int          cyc = 0;
   int          done_n = 0;
   int          flush_n = 0;
   int          flush_cyc = 0;
   int          stall_err = 0;
   logic        prev_stall = 1'b0;
   logic [63:0] prev_data = 64'd0;
   logic        prev_last = 1'b0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (m_axis_tvalid && m_axis_tready && out_n < 512) begin
         out_data[out_n] <= m_axis_tdata;
         out_last[out_n] <= m_axis_tlast;
         out_cyc[out_n]  <= cyc;
         out_n           <= out_n + 1;
      end
      if (pkt_done) done_n <= done_n + 1;
      if (to_flush) begin
         flush_n   <= flush_n + 1;
         flush_cyc <= cyc;
      end
      if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last))
         stall_err <= stall_err + 1;
      prev_stall <= m_axis_tvalid & !m_axis_tready & !rst;
      prev_data  <= m_axis_tdata;
      prev_last  <= m_axis_tlast;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Offer one word, wait (bounded) for acceptance; e is the accepting edge number
   task automatic send(input logic [63:0] d, output int e);
      int n;
      n = 0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      #1;
      while (!s_axis_tready && n < 200) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (!s_axis_tready) begin
         checks++;
         errors++;
         $display("FAIL send_accept: s_axis_tready=%b required 1 for word %h", s_axis_tready, d);
      end
      e = cyc + 1;
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
   endtask

   task automatic do_reset();
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 64'd0;
      m_axis_tready = 1'b1;
      pkt_len = 16'd4;
      timeout = 16'd0;
      rst = 1'b1;
      tick(3);
      checks += 6;
      if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
      if (m_axis_tdata !== 64'd0) begin errors++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
      if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
      if (pkt_done !== 1'b0) begin errors++; $display("FAIL reset_pkt_done: got %b want 0", pkt_done); end
      if (to_flush !== 1'b0) begin errors++; $display("FAIL reset_to_flush: got %b want 0", to_flush); end
      if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b want 1", s_axis_tready); end
      rst = 1'b0;
      tick(1);
   endtask

   task automatic test_back_to_back();
      int base, d0, e, e_first;
      logic exp_b;
      do_reset();
      pkt_len = 16'd4;
      timeout = 16'd0;
      base = out_n;
      d0 = done_n;
      e_first = 0;
      for (int i = 0; i < 8; i++) begin
         send(64'(i), e);
         if (i == 0) e_first = e;
         checks++;
         if (e !== e_first + i) begin errors++; $display("FAIL b2b_accept_edge[%0d]: got %0d want %0d", i, e, e_first + i); end
      end
      tick(6);
      checks += 3;
      if (out_n - base !== 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", out_n - base); end
      if (done_n - d0 !== 2) begin errors++; $display("FAIL b2b_pkt_done: got %0d want 2", done_n - d0); end
      if (out_cyc[base] !== e_first + 1) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", out_cyc[base], e_first + 1); end
      for (int i = 0; i < 8; i++) begin
         exp_b = ((i % 4) == 3);
         checks += 2;
         if (out_data[base+i] !== 64'(i)) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, out_data[base+i], 64'(i)); end
         if (out_last[base+i] !== exp_b) begin errors++; $display("FAIL b2b_tlast[%0d]: got %b want %b", i, out_last[base+i], exp_b); end
         if (i > 0) begin
            checks++;
            if (out_cyc[base+i] !== out_cyc[base+i-1] + 1) begin errors++; $display("FAIL b2b_bubble[%0d]: got edge %0d want %0d", i, out_cyc[base+i], out_cyc[base+i-1] + 1); end
         end
      end
   endtask

   task automatic test_timeout();
      int base, f0, d0, e0, e1, e;
      logic [5:0] exp_last;
      do_reset();
      pkt_len = 16'd4;
      timeout = 16'd10;
      base = out_n;
      f0 = flush_n;
      d0 = done_n;
      send(64'hA0, e0);
      send(64'hA1, e1);
      tick(15);
      for (int i = 2; i < 6; i++) send(64'hA0 + 64'(i), e);
      tick(6);
      checks += 2;
      if (out_n - base !== 6) begin errors++; $display("FAIL to_count: got %0d want 6", out_n - base); end
      if (out_cyc[base] !== e1) begin errors++; $display("FAIL to_first_edge: got %0d want %0d", out_cyc[base], e1); end
`ifdef AXIS_PKT_FRAMER_TIMEOUT_EN
      exp_last = 6'b100010;
      checks += 4;
      if (flush_n - f0 !== 1) begin errors++; $display("FAIL to_flush_count: got %0d want 1", flush_n - f0); end
      if (flush_cyc !== e1 + 10) begin errors++; $display("FAIL to_flush_edge: got %0d want %0d", flush_cyc, e1 + 10); end
      if (out_cyc[base+1] !== e1 + 11) begin errors++; $display("FAIL to_tlast_edge: got %0d want %0d", out_cyc[base+1], e1 + 11); end
      if (done_n - d0 !== 2) begin errors++; $display("FAIL to_pkt_done: got %0d want 2", done_n - d0); end
`else
      exp_last = 6'b001000;
      checks += 3;
      if (flush_n - f0 !== 0) begin errors++; $display("FAIL to_flush_count: got %0d want 0", flush_n - f0); end
      if (out_cyc[base+1] !== e1 + 1) begin errors++; $display("FAIL to_fixed_latency: got %0d want %0d", out_cyc[base+1], e1 + 1); end
      if (done_n - d0 !== 1) begin errors++; $display("FAIL to_pkt_done: got %0d want 1", done_n - d0); end
`endif
      for (int i = 0; i < 6; i++) begin
         checks += 2;
         if (out_data[base+i] !== 64'hA0 + 64'(i)) begin errors++; $display("FAIL to_data[%0d]: got %h want %h", i, out_data[base+i], 64'hA0 + 64'(i)); end
         if (out_last[base+i] !== exp_last[i]) begin errors++; $display("FAIL to_tlast[%0d]: got %b want %b", i, out_last[base+i], exp_last[i]); end
      end
   endtask

   task automatic test_accept_wins();
      int base, f0, e0, e1, e;
      do_reset();
      pkt_len = 16'd4;
      timeout = 16'd5;
      base = out_n;
      f0 = flush_n;
      send(64'hB0, e0);
      tick(4);
      send(64'hB1, e1);
      send(64'hB2, e);
      send(64'hB3, e);
      tick(20);
      checks += 3;
      if (e1 !== e0 + 5) begin errors++; $display("FAIL aw_accept_edge: got %0d want %0d", e1, e0 + 5); end
      if (flush_n - f0 !== 0) begin errors++; $display("FAIL aw_flush: got %0d want 0", flush_n - f0); end
      if (out_n - base !== 4) begin errors++; $display("FAIL aw_count: got %0d want 4", out_n - base); end
`ifdef AXIS_PKT_FRAMER_TIMEOUT_EN
      checks++;
      if (out_cyc[base] !== e1) begin errors++; $display("FAIL aw_hold_edge: got %0d want %0d", out_cyc[base], e1); end
`else
      checks++;
      if (out_cyc[base] !== e0 + 1) begin errors++; $display("FAIL aw_hold_edge: got %0d want %0d", out_cyc[base], e0 + 1); end
`endif
      for (int i = 0; i < 4; i++) begin
         checks += 2;
         if (out_data[base+i] !== 64'hB0 + 64'(i)) begin errors++; $display("FAIL aw_data[%0d]: got %h want %h", i, out_data[base+i], 64'hB0 + 64'(i)); end
         if (out_last[base+i] !== (i == 3)) begin errors++; $display("FAIL aw_tlast[%0d]: got %b want %b", i, out_last[base+i], (i == 3)); end
      end
   endtask

   task automatic test_random_ready();
      int base, s0, cur, n;
      logic acc;
      do_reset();
      pkt_len = 16'd3;
      timeout = 16'd0;
      base = out_n;
      s0 = stall_err;
      cur = 0;
      n = 0;
      while (cur < 30 && n < 2000) begin
         m_axis_tready = 1'($urandom_range(0, 1));
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = 64'h100 + 64'(cur);
         #1;
         acc = s_axis_tready;
         @(posedge clk);
         #1;
         if (acc) cur++;
         n++;
      end
      s_axis_tvalid = 1'b0;
      while (out_n - base < 30 && n < 2000) begin
         m_axis_tready = 1'($urandom_range(0, 1));
         tick(1);
         n++;
      end
      m_axis_tready = 1'b1;
      tick(4);
      checks += 3;
      if (cur !== 30) begin errors++; $display("FAIL rr_accepted: got %0d want 30", cur); end
      if (out_n - base !== 30) begin errors++; $display("FAIL rr_count: got %0d want 30", out_n - base); end
      if (stall_err - s0 !== 0) begin errors++; $display("FAIL rr_stable: got %0d unstable stalls want 0", stall_err - s0); end
      for (int i = 0; i < 30; i++) begin
         checks += 2;
         if (out_data[base+i] !== 64'h100 + 64'(i)) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", i, out_data[base+i], 64'h100 + 64'(i)); end
         if (out_last[base+i] !== ((i % 3) == 2)) begin errors++; $display("FAIL rr_tlast[%0d]: got %b want %b", i, out_last[base+i], ((i % 3) == 2)); end
      end
   endtask

   task automatic test_pkt_len();
      int base, e, e_first;
      logic [5:0] exp_last;
      do_reset();
      pkt_len = 16'd0;
      timeout = 16'd0;
      base = out_n;
      e_first = 0;
      for (int i = 0; i < 3; i++) begin
         send(64'hC0 + 64'(i), e);
         if (i == 0) e_first = e;
      end
      tick(4);
      checks++;
      if (out_n - base !== 3) begin errors++; $display("FAIL len0_count: got %0d want 3", out_n - base); end
      for (int i = 0; i < 3; i++) begin
         checks += 2;
         if (out_last[base+i] !== 1'b1) begin errors++; $display("FAIL len0_tlast[%0d]: got %b want 1", i, out_last[base+i]); end
         if (out_cyc[base+i] !== e_first + 1 + i) begin errors++; $display("FAIL len0_edge[%0d]: got %0d want %0d", i, out_cyc[base+i], e_first + 1 + i); end
      end
      pkt_len = 16'd4;
      base = out_n;
      exp_last = 6'b101000;
      send(64'hD0, e);
      send(64'hD1, e);
      pkt_len = 16'd2;
      for (int i = 2; i < 6; i++) send(64'hD0 + 64'(i), e);
      tick(6);
      checks++;
      if (out_n - base !== 6) begin errors++; $display("FAIL lenchg_count: got %0d want 6", out_n - base); end
      for (int i = 0; i < 6; i++) begin
         checks += 2;
         if (out_data[base+i] !== 64'hD0 + 64'(i)) begin errors++; $display("FAIL lenchg_data[%0d]: got %h want %h", i, out_data[base+i], 64'hD0 + 64'(i)); end
         if (out_last[base+i] !== exp_last[i]) begin errors++; $display("FAIL lenchg_tlast[%0d]: got %b want %b", i, out_last[base+i], exp_last[i]); end
      end
   endtask

   task automatic test_reset_mid();
      int base, e;
      do_reset();
      pkt_len = 16'd4;
      timeout = 16'd0;
      m_axis_tready = 1'b0;
      send(64'hE0, e);
      send(64'hE1, e);
      checks += 3;
      if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rm_full_tready: got %b want 0", s_axis_tready); end
      if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL rm_full_tvalid: got %b want 1", m_axis_tvalid); end
      if (m_axis_tdata !== 64'hE0) begin errors++; $display("FAIL rm_full_tdata: got %h want %h", m_axis_tdata, 64'hE0); end
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      checks += 2;
      if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rm_tvalid: got %b want 0", m_axis_tvalid); end
      if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rm_tready: got %b want 1", s_axis_tready); end
      m_axis_tready = 1'b1;
      base = out_n;
      for (int i = 0; i < 4; i++) send(64'hF0 + 64'(i), e);
      tick(5);
      checks++;
      if (out_n - base !== 4) begin errors++; $display("FAIL rm_count: got %0d want 4", out_n - base); end
      for (int i = 0; i < 4; i++) begin
         checks += 2;
         if (out_data[base+i] !== 64'hF0 + 64'(i)) begin errors++; $display("FAIL rm_data[%0d]: got %h want %h", i, out_data[base+i], 64'hF0 + 64'(i)); end
         if (out_last[base+i] !== (i == 3)) begin errors++; $display("FAIL rm_tlast[%0d]: got %b want %b", i, out_last[base+i], (i == 3)); end
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_timeout();
      test_accept_wins();
      test_random_ready();
      test_pkt_len();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog expired");
   end

endmodule
